// File: rtl/contador_arbitrario_pkg.sv
// Shared constants for the arbitrary 10-state counter: width, period and named states.
`timescale 1ns/1ps
package contador_arbitrario_pkg;

    localparam int WIDTH   = 4;
    localparam int SEQ_LEN = 10;

    // Sequence order is S0 -> S1 -> ... -> S9 -> S0; every other code is unused.
    typedef enum logic [WIDTH-1:0] {
        S0 = 4'd0,
        S1 = 4'd3,
        S2 = 4'd5,
        S3 = 4'd6,
        S4 = 4'd9,
        S5 = 4'd10,
        S6 = 4'd12,
        S7 = 4'd15,
        S8 = 4'd1,
        S9 = 4'd14
    } state_e;

    localparam logic [WIDTH-1:0] RESET_STATE = 4'd0;

endpackage

// File: rtl/contador_arbitrario_nand_if.sv
// Observation bundle for the counter outputs (state and optional terminal-count flag).
`timescale 1ns/1ps
interface contador_arbitrario_nand_if;
    import contador_arbitrario_pkg::*;

    logic [WIDTH-1:0] Q;
    logic             T;

    modport master (output Q, output T);
    modport slave  (input  Q, input  T);

endinterface

// File: rtl/contador_arbitrario_nand_biestable_d.sv
// D flip-flop with asynchronous active-high reset; one bit of counter state.
`timescale 1ns/1ps
module biestable_d (
    output logic Q,
    input  logic D,
    input  logic C,
    input  logic R
);

    logic q_q;

    always_ff @(posedge C or posedge R) begin
        if (R) q_q <= 1'b0;
        else   q_q <= D;
    end

    assign Q = q_q;

endmodule

// File: rtl/contador_arbitrario_nand.sv
// Arbitrary 10-state counter 0,3,5,6,9,10,12,15,1,14 with NAND-only next-state logic.
// Optional terminal-count output T (Q==14) when CONTADOR_ARBITRARIO_TC_EN is defined.
`timescale 1ns/1ps
module contador_arbitrario_nand
    import contador_arbitrario_pkg::*;
(
    output logic [WIDTH-1:0] Q,
    input  logic             C,
    input  logic             R
`ifdef CONTADOR_ARBITRARIO_TC_EN
    ,
    output logic             T
`endif
);

    logic q3, q2, q1, q0;
    logic d3, d2, d1, d0;
    logic n3, n2, n1, n0;

    // Literal complements (a=q3, b=q2, c=q1, d=q0)
    nand u_inv3 (n3, q3, q3);
    nand u_inv2 (n2, q2, q2);
    nand u_inv1 (n1, q1, q1);
    nand u_inv0 (n0, q0, q0);

    // Shared product terms, active low
    logic p_bncd, p_m6, p_m10, p_m12, p_anbd, p_ancd, p_anbnc, p_m0, p_m3, p_m15;

    nand u_p_bncd  (p_bncd,  n2, n1, q0);          // b'c'd   (1, 9)
    nand u_p_m6    (p_m6,    n3, q2, q1, n0);      // a'bcd'
    nand u_p_m10   (p_m10,   q3, n2, q1, n0);      // ab'cd'
    nand u_p_m12   (p_m12,   q3, q2, n1, n0);      // abc'd'
    nand u_p_anbd  (p_anbd,  n3, n2, q0);          // a'b'd   (1, 3)
    nand u_p_ancd  (p_ancd,  n3, n1, q0);          // a'c'd   (1, 5)
    nand u_p_anbnc (p_anbnc, n3, n2, n1);          // a'b'c'  (0, 1)
    nand u_p_m0    (p_m0,    n3, n2, n1, n0);
    nand u_p_m3    (p_m3,    n3, n2, q1, q0);
    nand u_p_m15   (p_m15,   q3, q2, q1, q0);

    nand u_d3 (d3, p_bncd,  p_m6,   p_m10,  p_m12);
    nand u_d2 (d2, p_anbd,  p_ancd, p_m10,  p_m12);
    nand u_d1 (d1, p_anbnc, p_ancd, p_bncd, p_m12);

    // D0 has five isolated minterms; OR the first four, then fold in m15.
    logic g0, g0_n;
    nand u_d0a (g0,   p_m0, p_m3, p_m6, p_m12);
    nand u_d0b (g0_n, g0,   g0);
    nand u_d0  (d0,   g0_n, p_m15);

    biestable_d u_ff3 (.Q(q3), .D(d3), .C(C), .R(R));
    biestable_d u_ff2 (.Q(q2), .D(d2), .C(C), .R(R));
    biestable_d u_ff1 (.Q(q1), .D(d1), .C(C), .R(R));
    biestable_d u_ff0 (.Q(q0), .D(d0), .C(C), .R(R));

    assign Q = {q3, q2, q1, q0};

`ifdef CONTADOR_ARBITRARIO_TC_EN
    logic p_m14;
    nand u_p_m14 (p_m14, q3, q2, q1, n0);
    nand u_t     (T,     p_m14, p_m14);
`endif

endmodule

// File: tb/tb_contador_arbitrario_nand.sv
// Scoreboard bench for contador_arbitrario_nand; reference model walks the state table.
`timescale 1ns/1ps
module tb_contador_arbitrario_nand;
    import contador_arbitrario_pkg::*;

    typedef struct packed {
        logic [3:0] q;
        logic       t;
    } exp_t;

    logic C;
    logic R;
    bit   clk_en;

    contador_arbitrario_nand_if bus ();

    contador_arbitrario_nand dut (
        .Q(bus.Q),
        .C(C),
        .R(R)
`ifdef CONTADOR_ARBITRARIO_TC_EN
        ,
        .T(bus.T)
`endif
    );

`ifndef CONTADOR_ARBITRARIO_TC_EN
    assign bus.T = 1'b0;
`endif

    exp_t        exp_q[$];
    int unsigned n_checks;
    int unsigned n_errors;
    event        ev_async;
    logic [3:0]  force_v;
    logic [3:0]  st;

    function automatic logic [3:0] model_next(logic [3:0] s);
        state_e tbl [SEQ_LEN] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
        for (int i = 0; i < SEQ_LEN; i++)
            if (tbl[i] == s) return tbl[(i + 1) % SEQ_LEN];
        return RESET_STATE;
    endfunction

    initial begin
        C = 1'b0;
        forever begin
            #5;
            if (clk_en) C = ~C;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: compare whenever the DUT output should have settled
    initial begin
        exp_t e;
        forever begin
            @(posedge C or ev_async);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.Q !== e.q) begin
                    n_errors++;
                    $display("FAIL q_state: got %0d required %0d at %0t", bus.Q, e.q, $time);
                end
`ifdef CONTADOR_ARBITRARIO_TC_EN
                n_checks++;
                if (bus.T !== e.t) begin
                    n_errors++;
                    $display("FAIL t_flag: got %b required %b (Q req %0d) at %0t", bus.T, e.t, e.q, $time);
                end
`endif
            end
        end
    end

    task automatic push(logic [3:0] q);
        exp_t e;
        e.q = q;
        e.t = (q == S9);
        exp_q.push_back(e);
    endtask

    task automatic edge_exp(logic [3:0] q);
        push(q);
        @(posedge C);
        #3;
    endtask

    task automatic async_exp(logic [3:0] q);
        push(q);
        -> ev_async;
        #3;
    endtask

    initial begin
        logic [3:0] ill_tbl [6] = '{4'd7, 4'd2, 4'd8, 4'd11, 4'd13, 4'd4};
        n_checks = 0;
        n_errors = 0;
        force_v  = '0;
        clk_en   = 1'b0;
        R        = 1'b1;

        // Reset with the clock stopped
        #4;
        async_exp(RESET_STATE);

        // Reset held while the clock runs
        clk_en = 1'b1;
        repeat (3) edge_exp(RESET_STATE);

        // One full period after release
        R  = 1'b0;
        st = RESET_STATE;
        for (int i = 0; i < SEQ_LEN; i++) begin
            st = model_next(st);
            edge_exp(st);
        end

        // Long random run with occasional asynchronous reset pulses
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                R = 1'b1;
                async_exp(RESET_STATE);
                st = RESET_STATE;
                if ($urandom_range(0, 1) == 1) edge_exp(RESET_STATE);
                R = 1'b0;
            end
            st = model_next(st);
            edge_exp(st);
        end

        // Mid-sequence reset at state 12
        for (int i = 0; i < 2 * SEQ_LEN && st != S6; i++) begin
            st = model_next(st);
            edge_exp(st);
        end
        R = 1'b1;
        async_exp(RESET_STATE);
        R  = 1'b0;
        st = model_next(RESET_STATE);
        edge_exp(st);

        // Unused-state recovery
        for (int i = 0; i < 6; i++) begin
            force_v = ill_tbl[i];
            force dut.u_ff3.q_q = force_v[3];
            force dut.u_ff2.q_q = force_v[2];
            force dut.u_ff1.q_q = force_v[1];
            force dut.u_ff0.q_q = force_v[0];
            async_exp(force_v);
            release dut.u_ff3.q_q;
            release dut.u_ff2.q_q;
            release dut.u_ff1.q_q;
            release dut.u_ff0.q_q;
            edge_exp(model_next(force_v));
            st = model_next(RESET_STATE);
            edge_exp(st);
        end

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge C);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_arbitrario_nand.md
Name: contador_arbitrario_nand

Overview:
- 4-bit synchronous counter that steps through a fixed, non-binary ("arbitrary") 10-state sequence on each rising clock edge.
- Built structurally: next-state logic uses only NAND gates, and state is held in four D flip-flops.
- Standalone teaching and demo block whose output drives waveform inspection.
- Functionally identical to the team's AND/OR version of the same counter.

Parameters:
- None. Width and sequence are fixed.

Ports:
- C  input  1  clock; all state changes on rising edge.
- R  input  1  reset; asynchronous, active-high. Forces Q to 0 immediately.
- Q  output 4  current counter state, registered.
- Declaration order is Q, C, R, so positional instantiation (Q, C) of the existing bench still binds.

Behaviour:
- Reset:
  - While R=1, Q=4'd0 regardless of C.
  - Release is sampled by the next rising edge of C.
  - If R is never asserted, Q is undefined (X in simulation).
- Sequence, one step per rising edge of C with R=0, using decimal Q values:
  - 0→3→5→6→9→10→12→15→1→14→0, then repeats.
  - Period is 10 clocks.
- Unused states 2, 4, 7, 8, 11 and 13 go to 0 on the next edge (self-correcting). No lock-up is possible.
- Latency: Q changes only after a rising edge of C, with no combinational path from C to Q beyond clock-to-Q.
- Reset mid-sequence: Q drops to 0 asynchronously, and the sequence restarts at 0→3 after release.
- Reset asserted on the same edge as a count: reset wins, and Q=0.
- Structure rules:
  - Next-state equations D3..D0 are derived from the table above, minimised as sum-of-products, then implemented as NAND-NAND.
  - Only the Verilog nand primitive is used (2/3/4-input). Inversion is a NAND with tied inputs.
  - No behavioural operators are used in the next-state logic.
  - Flip-flops are the only behavioural code: always @(posedge C or posedge R).

Optional Feature:
- Macro CONTADOR_ARBITRARIO_TC_EN.
- When defined:
  - Extra output T (1 bit) is appended after R.
  - T=1 combinationally while Q==14, the last state before wrap; otherwise T=0.
  - T=0 during reset.
  - T is built from NAND gates only.
- When undefined: port T and its logic are absent, and Q behaviour is unchanged.

Decomposition:
- Shared package contador_arbitrario_pkg holds:
  - WIDTH=4 and SEQ_LEN=10.
  - Named state constants S0=0, S1=3, S2=5, S3=6, S4=9, S5=10, S6=12, S7=15, S8=1, S9=14.
  - The RESET_STATE constant (0).
- Benches use these constants for expected-value tables.
- One sub-module, biestable_d: a D flip-flop with asynchronous active-high reset, ports (Q, D, C, R), instantiated four times.

Test Plan:
- Reset value: drive R=1 with C toggling → Q=0 held throughout. Assert R with C stopped → Q=0 without any clock edge.
- Full sequence: release R, apply 10 rising edges → Q = 3, 5, 6, 9, 10, 12, 15, 1, 14, 0, in order.
- Long run: C period 2 time units for 500 time units (≈250 edges) → Q matches the sequence modulo 10 at every edge, with Q never in {2, 4, 7, 8, 11, 13}.
- Mid-sequence reset: pulse R asynchronously while Q=12 → Q=0 immediately. The first edge after release gives Q=3.
- Illegal-state recovery: force the flip-flop outputs to 7, 2, 8, 11, 13 and 4 in turn, then release → after one edge Q=0, after the next Q=3.
- With CONTADOR_ARBITRARIO_TC_EN defined: T=1 exactly during Q=14 (one clock in every ten) and T=0 during reset. Without the macro, the bench compiles with the (Q, C, R) port list only.
